// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, byte-strobed writes, optional bypass, debug port
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0] dbg_ra,
  output logic [DATA_W-1:0] dbg_rd,
  output logic [15:0]       wr_cnt
);
  localparam int NR = 2**ADDR_W;
  localparam int NB = DATA_W/8;
  logic [DATA_W-1:0] regs_q [NR];
  logic [DATA_W-1:0] regs_d [NR];
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [DATA_W-1:0] bmask, merged;
  logic wr_hit, commit;
  always_comb begin
    bmask = '0;
    for (int i = 0; i < NB; i++) bmask[i*8 +: 8] = {8{wstrb[i]}};
    merged = (wd & bmask) | (regs_q[wa] & ~bmask);
    wr_hit = we && (wa != '0);
    commit = wr_hit && (wstrb != '0);
    regs_d = regs_q;
    if (commit) regs_d[wa] = merged;
    wr_cnt_d = wr_cnt_q + 16'(commit);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) regs_q[i] <= '0;
      wr_cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
  assign rd1 = (!rst_n || ra1 == '0) ? '0 : (BYPASS && wr_hit && ra1 == wa) ? merged : regs_q[ra1];
  assign rd2 = (!rst_n || ra2 == '0) ? '0 : (BYPASS && wr_hit && ra2 == wa) ? merged : regs_q[ra2];
  assign dbg_rd = (!rst_n || dbg_ra == '0) ? '0 : regs_q[dbg_ra];
  assign wr_cnt = wr_cnt_q;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed checks of reg_file with and without bypass
module tb_reg_file;
  logic clk = 0, rst_n;
  logic [4:0] ra1, ra2, wa, dbg_ra;
  logic [31:0] wd;
  logic [3:0] wstrb;
  logic we;
  logic [31:0] b_rd1, b_rd2, b_dbg, n_rd1, n_rd2, n_dbg;
  logic [15:0] b_cnt, n_cnt;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  reg_file #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .rd1(b_rd1), .ra2(ra2), .rd2(b_rd2),
    .we(we), .wa(wa), .wd(wd), .wstrb(wstrb), .dbg_ra(dbg_ra), .dbg_rd(b_dbg), .wr_cnt(b_cnt)
  );
  reg_file #(.BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .rd1(n_rd1), .ra2(ra2), .rd2(n_rd2),
    .we(we), .wa(wa), .wd(wd), .wstrb(wstrb), .dbg_ra(dbg_ra), .dbg_rd(n_dbg), .wr_cnt(n_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    we = 1; wa = a; wd = d; wstrb = s;
    @(posedge clk);
    #1 we = 0;
  endtask
  initial begin
    rst_n = 0; we = 0; wa = 0; wd = 0; wstrb = 0; ra1 = 0; ra2 = 0; dbg_ra = 0;
    #12 rst_n = 1;
    wr(1, 32'hDEADBEEF, 4'hF);
    wr(31, 32'h0BADF00D, 4'hF);
    ra1 = 1; dbg_ra = 31; #1;
    chk("pre_rst_r1", b_rd1, 32'hDEADBEEF);
    chk("pre_rst_r31", b_dbg, 32'h0BADF00D);
    @(negedge clk); #2 rst_n = 0; #1;
    chk("in_rst_rd1", b_rd1, 0);
    #1 rst_n = 1;
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i); dbg_ra = 5'(i); #1;
      chk("rst_b_rd1", b_rd1, 0); chk("rst_b_rd2", b_rd2, 0); chk("rst_b_dbg", b_dbg, 0);
      chk("rst_n_rd1", n_rd1, 0); chk("rst_n_rd2", n_rd2, 0); chk("rst_n_dbg", n_dbg, 0);
    end
    chk("rst_cnt", b_cnt, 0);
    chk("rst_cnt_nb", n_cnt, 0);
    wr(5, 32'h00000001, 4'hF);
    wr(6, 32'h00000002, 4'hF);
    ra1 = 5; ra2 = 6; #1;
    chk("full_rd1", b_rd1, 32'h1);
    chk("full_rd2", b_rd2, 32'h2);
    chk("full_cnt", b_cnt, 2);
    wr(7, 32'hAABBCCDD, 4'hF);
    wr(7, 32'h11223344, 4'b0101);
    dbg_ra = 7; ra1 = 7; #1;
    chk("strb_dbg", b_dbg, 32'hAA22CC44);
    chk("strb_nb_rd1", n_rd1, 32'hAA22CC44);
    chk("strb_cnt", b_cnt, 4);
    wr(0, 32'hFFFFFFFF, 4'hF);
    ra1 = 0; #1;
    chk("r0_rd1", b_rd1, 0);
    chk("r0_cnt", b_cnt, 4);
    wr(5, 32'hFFFFFFFF, 4'h0);
    ra1 = 5; #1;
    chk("nostrb_r5", b_rd1, 32'h1);
    chk("nostrb_cnt", b_cnt, 4);
    wr(9, 32'h12345678, 4'hF);
    chk("pre_byp_cnt", b_cnt, 5);
    @(negedge clk);
    we = 1; wa = 9; wd = 32'hCAFEF00D; wstrb = 4'b0011; ra1 = 9; ra2 = 9; dbg_ra = 9; #1;
    chk("byp_rd1", b_rd1, 32'h1234F00D);
    chk("byp_rd2", b_rd2, 32'h1234F00D);
    chk("byp_dbg", b_dbg, 32'h12345678);
    chk("nob_rd1", n_rd1, 32'h12345678);
    chk("nob_rd2", n_rd2, 32'h12345678);
    ra2 = 5; #1;
    chk("byp_indep_rd2", b_rd2, 32'h1);
    ra1 = 0; #1;
    chk("byp_ra0", b_rd1, 0);
    ra1 = 9;
    @(posedge clk); #1 we = 0; #1;
    chk("post_b_rd1", b_rd1, 32'h1234F00D);
    chk("post_n_rd1", n_rd1, 32'h1234F00D);
    chk("post_n_dbg", n_dbg, 32'h1234F00D);
    chk("post_cnt", b_cnt, 6);
    @(negedge clk);
    we = 1; wa = 1; wd = 32'h5A5A5A5A; wstrb = 4'hF;
    repeat (65535 - 6) @(posedge clk);
    #1 we = 0;
    chk("cnt_ffff", b_cnt, 16'hFFFF);
    ra1 = 1; #1;
    chk("bulk_r1", b_rd1, 32'h5A5A5A5A);
    wr(2, 32'h22222222, 4'hF);
    chk("cnt_wrap", b_cnt, 0);
    chk("cnt_wrap_nb", n_cnt, 0);
    @(negedge clk);
    we = 1; wa = 3; wd = 32'h55555555; wstrb = 4'hF; ra1 = 3; dbg_ra = 3;
    #4 rst_n = 0; #1;
    chk("rstwr_rd1", b_rd1, 0);
    @(posedge clk); #1 we = 0;
    @(negedge clk); rst_n = 1; #1;
    chk("rstwr_dbg", b_dbg, 0);
    chk("rstwr_nb_rd1", n_rd1, 0);
    chk("rstwr_cnt", b_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
